// File: rtl/pixel_plot_writer.sv
// Pixel stream consumer: buffers (x, y, colour, last) in a small FIFO, clips
// off-screen pixels and turns the rest into stallable framebuffer writes.
module pixel_plot_writer #(
   parameter int FIFO_DEPTH = 4,
   parameter int COLOUR_W   = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [8:0]          in_x,
   input  logic [7:0]          in_y,
   input  logic [COLOUR_W-1:0] in_colour,
   input  logic                in_last,
   input  logic                clear,
   output logic [16:0]         mem_addr,
   output logic [COLOUR_W-1:0] mem_data,
   output logic                mem_we,
   input  logic                mem_ready,
   output logic                frame_done,
   output logic [16:0]         pixels_written,
   output logic [7:0]          clipped_count
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int EW = 18 + COLOUR_W;

   typedef enum logic {IDLE, WRITE} state_t;

   logic [EW-1:0]       fifo_q [FIFO_DEPTH];
   logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]       count_q, count_d;
   logic                in_ready_q, in_ready_d;
   state_t              state_q, state_d;
   logic [16:0]         mem_addr_q, mem_addr_d;
   logic [COLOUR_W-1:0] mem_data_q, mem_data_d;
   logic                mem_we_q, mem_we_d;
   logic                last_q, last_d;
   logic                frame_done_q, frame_done_d;
   logic [16:0]         pixels_written_q, pixels_written_d;
   logic [7:0]          clipped_count_q, clipped_count_d;

   logic                push, pop, non_empty, write_done;
   logic [EW-1:0]       head;
   logic [8:0]          head_x;
   logic [7:0]          head_y;
   logic [COLOUR_W-1:0] head_colour;
   logic                head_last, head_in_range, head_clip_last;

   assign non_empty  = (count_q != '0);
   assign push       = in_valid && in_ready_q;
   assign write_done = (state_q == WRITE) && mem_ready;
   assign head       = fifo_q[rd_ptr_q];
   assign {head_x, head_y, head_colour, head_last} = head;
   assign head_in_range  = (head_x < 9'd320) && (head_y < 8'd240);
   assign head_clip_last = head_last && !head_in_range;

   // A finishing last-tagged write and a clipped last-tagged head would retire
   // on the same edge and merge into one pulse, so the clipped one waits a cycle.
   assign pop = non_empty &&
                ((state_q == IDLE) || (write_done && !(last_q && head_clip_last)));

   always_comb begin
      wr_ptr_d         = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d         = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d          = count_q + CW'(push) - CW'(pop);
      in_ready_d       = (count_d != CW'(FIFO_DEPTH));
      state_d          = state_q;
      mem_addr_d       = mem_addr_q;
      mem_data_d       = mem_data_q;
      mem_we_d         = mem_we_q;
      last_d           = last_q;
      frame_done_d     = write_done && last_q;
      pixels_written_d = pixels_written_q + 17'(write_done);
      clipped_count_d  = clipped_count_q;

      if (write_done) begin
         state_d  = IDLE;
         mem_we_d = 1'b0;
      end

      if (pop) begin
         if (head_in_range) begin
            state_d    = WRITE;
            mem_we_d   = 1'b1;
            mem_addr_d = ({9'd0, head_y} << 8) + ({9'd0, head_y} << 6) + {8'd0, head_x};
            mem_data_d = head_colour;
            last_d     = head_last;
         end else begin
            if (clipped_count_q != 8'hFF)
               clipped_count_d = clipped_count_q + 8'd1;
            if (head_last)
               frame_done_d = 1'b1;
         end
      end

      if (clear) begin
         pixels_written_d = '0;
         clipped_count_d  = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q         <= '0;
         rd_ptr_q         <= '0;
         count_q          <= '0;
         in_ready_q       <= 1'b1;
         state_q          <= IDLE;
         mem_addr_q       <= '0;
         mem_data_q       <= '0;
         mem_we_q         <= 1'b0;
         last_q           <= 1'b0;
         frame_done_q     <= 1'b0;
         pixels_written_q <= '0;
         clipped_count_q  <= '0;
      end else begin
         wr_ptr_q         <= wr_ptr_d;
         rd_ptr_q         <= rd_ptr_d;
         count_q          <= count_d;
         in_ready_q       <= in_ready_d;
         state_q          <= state_d;
         mem_addr_q       <= mem_addr_d;
         mem_data_q       <= mem_data_d;
         mem_we_q         <= mem_we_d;
         last_q           <= last_d;
         frame_done_q     <= frame_done_d;
         pixels_written_q <= pixels_written_d;
         clipped_count_q  <= clipped_count_d;
      end
   end

   // Storage carries no reset; occupancy is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (push)
         fifo_q[wr_ptr_q] <= {in_x, in_y, in_colour, in_last};
   end

   assign in_ready       = in_ready_q;
   assign mem_addr       = mem_addr_q;
   assign mem_data       = mem_data_q;
   assign mem_we         = mem_we_q;
   assign frame_done     = frame_done_q;
   assign pixels_written = pixels_written_q;
   assign clipped_count  = clipped_count_q;

endmodule

// File: tb/tb_pixel_plot_writer.sv
// Bench for pixel_plot_writer: directed scenarios plus a randomized run scored
// against a queue model of accepted pixels.
module tb_pixel_plot_writer;

   typedef struct packed {
      logic [8:0] x;
      logic [7:0] y;
      logic [2:0] c;
      logic       last;
   } pix_t;

   logic        clk, reset, in_valid, in_ready, in_last, clear;
   logic [8:0]  in_x;
   logic [7:0]  in_y;
   logic [2:0]  in_colour;
   logic [16:0] mem_addr;
   logic [2:0]  mem_data;
   logic        mem_we, mem_ready, frame_done;
   logic [16:0] pixels_written;
   logic [7:0]  clipped_count;

   pixel_plot_writer #(.FIFO_DEPTH(4), .COLOUR_W(3)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .in_y(in_y), .in_colour(in_colour), .in_last(in_last),
      .clear(clear), .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
      .mem_ready(mem_ready), .frame_done(frame_done),
      .pixels_written(pixels_written), .clipped_count(clipped_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   function automatic void chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endfunction

   function automatic int addr_of(pix_t p);
      return int'(p.y) * 320 + int'(p.x);
   endfunction

   function automatic bit on_screen(pix_t p);
      return (p.x < 320) && (p.y < 240);
   endfunction

   function automatic pix_t off_pix();
      pix_t r;
      if ($urandom_range(0, 1) == 1) begin
         r.x = 9'(320 + $urandom_range(0, 191));
         r.y = 8'($urandom_range(0, 255));
      end else begin
         r.x = 9'($urandom_range(0, 319));
         r.y = 8'(240 + $urandom_range(0, 15));
      end
      r.c = 3'($urandom_range(0, 7));
      r.last = 1'b0;
      return r;
   endfunction

   function automatic pix_t rand_pix();
      pix_t r;
      if ($urandom_range(0, 3) == 0) r = off_pix();
      else begin
         r.x = 9'($urandom_range(0, 319));
         r.y = 8'($urandom_range(0, 239));
         r.c = 3'($urandom_range(0, 7));
      end
      r.last = ($urandom_range(0, 4) == 0);
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input pix_t p);
      in_valid  = v;
      in_x      = p.x;
      in_y      = p.y;
      in_colour = p.c;
      in_last   = p.last;
   endtask

   // Reference model: every accepted pixel queued in order; writes must match
   // the next on-screen pixel, off-screen ones ahead of it are simply dropped.
   pix_t q[$];
   pix_t mp;
   int   fd_cnt = 0, acc_wr = 0, acc_clip = 0, acc_last = 0;
   logic        prev_valid = 1'b0, prev_we = 1'b0, prev_rdy = 1'b0;
   logic [16:0] prev_addr = '0;
   logic [2:0]  prev_data = '0;

   always @(posedge clk) begin
      if (reset) begin
         q.delete();
         prev_valid = 1'b0;
      end else begin
         if (prev_valid && prev_we && !prev_rdy) begin
            chk("stall_hold_we", mem_we, 1);
            chk("stall_hold_addr", mem_addr, prev_addr);
            chk("stall_hold_data", mem_data, prev_data);
         end
         if (mem_we && mem_ready) begin
            while (q.size() > 0 && !on_screen(q[0])) void'(q.pop_front());
            if (q.size() == 0) chk("unexpected_write", 1, 0);
            else begin
               mp = q.pop_front();
               chk("write_addr", mem_addr, addr_of(mp));
               chk("write_data", mem_data, mp.c);
            end
         end
         if (in_valid && in_ready) begin
            mp = '{x: in_x, y: in_y, c: in_colour, last: in_last};
            q.push_back(mp);
            if (on_screen(mp)) acc_wr++;
            else acc_clip++;
            if (mp.last) acc_last++;
         end
         if (frame_done) fd_cnt++;
         prev_valid = 1'b1;
         prev_we    = mem_we;
         prev_rdy   = mem_ready;
         prev_addr  = mem_addr;
         prev_data  = mem_data;
      end
   end

   pix_t px4 [8];
   pix_t p;
   int   k;
   logic rdy, saw_we;

   initial begin
      reset = 1'b1; clear = 1'b0; mem_ready = 1'b0;
      drive(1'b0, '0);
      #2;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_data", mem_data, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_pixels_written", pixels_written, 0);
      chk("rst_clipped_count", clipped_count, 0);
      step(); step();
      reset = 1'b0;
      step();

      // Single on-screen pixel
      mem_ready = 1'b1;
      drive(1'b1, '{x: 9'd10, y: 8'd20, c: 3'd5, last: 1'b1});
      step();
      drive(1'b0, '0);
      chk("t1_we_e0", mem_we, 0);
      step();
      chk("t1_we_e1", mem_we, 1);
      chk("t1_addr", mem_addr, 6410);
      chk("t1_data", mem_data, 5);
      step();
      chk("t1_we_e2", mem_we, 0);
      chk("t1_frame_done", frame_done, 1);
      chk("t1_pixels_written", pixels_written, 1);
      step();
      chk("t1_frame_done_end", frame_done, 0);
      chk("t1_we_e3", mem_we, 0);

      // Corner addresses back to back
      clear = 1'b1; step(); clear = 1'b0;
      chk("t2_clear", pixels_written, 0);
      drive(1'b1, '{x: 9'd319, y: 8'd239, c: 3'd2, last: 1'b0});
      step();
      drive(1'b1, '{x: 9'd0, y: 8'd0, c: 3'd7, last: 1'b0});
      step();
      drive(1'b0, '0);
      chk("t2_we_a", mem_we, 1);
      chk("t2_addr_a", mem_addr, 76799);
      step();
      chk("t2_we_b", mem_we, 1);
      chk("t2_addr_b", mem_addr, 0);
      chk("t2_data_b", mem_data, 7);
      step();
      chk("t2_we_end", mem_we, 0);
      chk("t2_pixels_written", pixels_written, 2);

      // Clipping
      drive(1'b1, '{x: 9'd320, y: 8'd5, c: 3'd1, last: 1'b1});
      step();
      drive(1'b1, '{x: 9'd7, y: 8'd240, c: 3'd1, last: 1'b0});
      step();
      drive(1'b0, '0);
      chk("t3_we_a", mem_we, 0);
      chk("t3_clipped_a", clipped_count, 1);
      chk("t3_frame_done_a", frame_done, 1);
      step();
      chk("t3_we_b", mem_we, 0);
      chk("t3_clipped_b", clipped_count, 2);
      chk("t3_frame_done_b", frame_done, 0);
      step();
      chk("t3_pixels_written", pixels_written, 2);

      // Stall capacity and release
      clear = 1'b1; step(); clear = 1'b0;
      for (int i = 0; i < 8; i++) px4[i] = '{x: 9'(i * 37), y: 8'(i * 29 + 1), c: 3'(i), last: 1'b0};
      mem_ready = 1'b0;
      k = 0;
      for (int i = 0; i < 10; i++) begin
         drive(k < 8, px4[(k < 8) ? k : 7]);
         rdy = in_ready;
         step();
         if (in_valid && rdy) k++;
      end
      chk("t4_accepted_stalled", k, 5);
      chk("t4_in_ready_full", in_ready, 0);
      chk("t4_we_held", mem_we, 1);
      chk("t4_addr_held", mem_addr, addr_of(px4[0]));
      mem_ready = 1'b1;
      saw_we = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive(k < 8, px4[(k < 8) ? k : 7]);
         rdy = in_ready;
         step();
         if (in_valid && rdy) k++;
         if (i < 4) saw_we = saw_we & mem_we;
      end
      chk("t4_back_to_back", saw_we, 1);
      chk("t4_written_5", pixels_written, 5);
      for (int i = 0; i < 40; i++) begin
         drive(k < 8, px4[(k < 8) ? k : 7]);
         rdy = in_ready;
         step();
         if (in_valid && rdy) k++;
      end
      drive(1'b0, '0);
      chk("t4_accepted_all", k, 8);
      chk("t4_written_8", pixels_written, 8);

      // Reset during a stalled write with a backlog
      mem_ready = 1'b0;
      k = 0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, px4[i]);
         rdy = in_ready;
         step();
         if (rdy) k++;
      end
      drive(1'b0, '0);
      chk("t5_accepted", k, 4);
      chk("t5_we_before", mem_we, 1);
      reset = 1'b1;
      #1;
      chk("t5_we_async", mem_we, 0);
      chk("t5_in_ready_async", in_ready, 1);
      chk("t5_pixels_written", pixels_written, 0);
      chk("t5_clipped", clipped_count, 0);
      step(); step();
      reset = 1'b0;
      mem_ready = 1'b1;
      saw_we = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         saw_we = saw_we | mem_we;
      end
      chk("t5_no_write_after", saw_we, 0);
      chk("t5_written_after", pixels_written, 0);

      // Clipped-count saturation and clear priority
      k = 0;
      for (int i = 0; i < 400 && k < 300; i++) begin
         drive(1'b1, off_pix());
         rdy = in_ready;
         step();
         if (rdy) k++;
      end
      drive(1'b0, '0);
      step(); step(); step();
      chk("t6_accepted", k, 300);
      chk("t6_saturated", clipped_count, 255);
      chk("t6_no_writes", pixels_written, 0);
      drive(1'b1, off_pix());
      step();
      drive(1'b0, '0);
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("t6_clear_wins", clipped_count, 0);
      step();
      chk("t6_clear_stays", clipped_count, 0);

      // Randomized traffic against the queue model
      fd_cnt = 0; acc_wr = 0; acc_clip = 0; acc_last = 0;
      for (int i = 0; i < 400; i++) begin
         p = rand_pix();
         drive($urandom_range(0, 3) != 0, p);
         mem_ready = ($urandom_range(0, 2) != 0);
         step();
      end
      drive(1'b0, '0);
      mem_ready = 1'b1;
      for (int i = 0; i < 30; i++) step();
      chk("rand_pixels_written", pixels_written, acc_wr);
      chk("rand_clipped", clipped_count, (acc_clip > 255) ? 255 : acc_clip);
      chk("rand_frame_done", fd_cnt, acc_last);
      chk("rand_idle", mem_we, 0);
      chk("rand_in_ready", in_ready, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pixel_plot_writer.md
# pixel_plot_writer

Consumer end of the drawing-coordinate stream. Accepts (x, y, colour) pixels produced by the display sequencers through a valid/ready handshake, buffers them in a small FIFO, clips anything outside the 320x240 screen, and converts the rest into framebuffer write requests (linear address = y*320 + x) with a memory-side stall input. It sits between the drawing sequencers and the VGA adapter's pixel memory port.

## Interface

- FIFO_DEPTH, 4, input FIFO entries (power of two, ≥2)
- COLOUR_W, 3, colour bits per pixel
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  pixel present on in_*
- in_ready  out  1  FIFO can accept; equals !fifo_full
- in_x  in  9  pixel column, legal 0..319
- in_y  in  8  pixel row, legal 0..239
- in_colour  in  COLOUR_W  pixel colour
- in_last  in  1  final pixel of the current drawing
- clear  in  1  synchronous clear of pixels_written and clipped_count only
- mem_addr  out  17  framebuffer address, y*320 + x
- mem_data  out  COLOUR_W  colour to write
- mem_we  out  1  write request; held until accepted
- mem_ready  in  1  memory accepts the request this cycle
- frame_done  out  1  one-cycle pulse when the last-tagged pixel retires
- pixels_written  out  17  count of completed writes, wraps at 2^17
- clipped_count  out  8  count of discarded pixels, saturates at 255

## Operation

- Push: in_valid && in_ready stores {x, y, colour, last}. No push while full, even if a pop occurs in the same cycle. No bypass: an entry accepted into an empty FIFO cannot pop until the following edge.
- Output FSM, two states:
  - IDLE (mem_we=0): if FIFO non-empty, pop the head.
  - WRITE (mem_we=1, mem_addr/mem_data/last held stable): when mem_ready=1, the write completes, pixels_written increments, and the FSM pops the next head in the same cycle if the FIFO is non-empty, otherwise returns to IDLE.
- Popped entry handling:
  - In-range entry (x<320 and y<240): load mem_addr = (y<<8)+(y<<6)+x, computed at 17 bits with no truncation, and load mem_data; go to WRITE.
  - Out-of-range entry: discard it, increment clipped_count (saturating), and go to or stay in IDLE. No memory request is made.
- frame_done pulses for one cycle after a last-tagged entry retires: for a written pixel, when its write completes; for a clipped pixel, when it is popped. Consecutive last-tagged entries produce separate pulses.
- Pixel order at the memory port equals acceptance order.
- clear: sets both counters to 0 on the next edge. If an increment happens in the same cycle, clear wins. The FIFO and FSM are unaffected.

## Timing

- Reset (asynchronous, takes effect immediately):
  - FIFO emptied, FSM in IDLE.
  - in_ready=1, mem_we=0, mem_addr=0, mem_data=0, frame_done=0, pixels_written=0, clipped_count=0.
- Reset asserted mid-write: the request is abandoned and mem_we drops without waiting for mem_ready. All buffered pixels are lost.
- Latency: a pixel accepted at edge E0 into an empty FIFO with the FSM in IDLE gives mem_we=1 after edge E1.
  - With mem_ready=1, the write completes at E2; pixels_written and frame_done update after E2.
  - A clipped pixel updates clipped_count and frame_done after E1.
- Throughput: one pixel per cycle while mem_ready stays high and the FIFO stays non-empty.
- Capacity under stall: FIFO_DEPTH entries plus the one held in WRITE. in_ready falls after the (FIFO_DEPTH+1)th acceptance when mem_ready stays 0 throughout.
- in_ready is a registered, full-flag-based output. It has no combinational path from in_valid or mem_ready.
- mem_addr, mem_data and mem_we are registered outputs and do not change while mem_we=1 && mem_ready=0.

## Test plan

- Push (10,20) colour 5 last=1, mem_ready=1 → mem_we high for exactly one cycle with mem_addr=6410, mem_data=5; frame_done pulses after E2; pixels_written=1.
- Push (319,239) then (0,0), mem_ready=1 → addresses 76799 then 0 on consecutive cycles; pixels_written=2.
- Push (320,5) last=1 and (7,240) → no mem_we; clipped_count=2; frame_done pulses once, for the first entry.
- mem_ready=0, push 8 pixels continuously → exactly 5 accepted, then in_ready=0. Release mem_ready → all 5 written in order, one per cycle, then the remaining 3 accepted.
- Reset asserted while mem_we=1 with 3 entries queued → mem_we=0 and in_ready=1 immediately, counters 0; no write occurs after reset is released.
- 300 off-screen pixels → clipped_count=255. Pulse clear together with a clipped pop → clipped_count=0.
